switch_debounce: RTL
====================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of independent switch inputs debounced in parallel.
REQ-002 Parameter DEBOUNCE_CYCLES, default 120000 (10 ms at 12 MHz), consecutive clk cycles a new level must persist before acceptance; legal range >= 1.
REQ-003 Parameter RESET_VAL, default all-zeros, WIDTH bits, value of sw_out during and after reset.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; assertion clears state immediately; deassertion is synchronised externally.
REQ-006 sw_in  input  WIDTH  raw asynchronous switch levels, bouncing.
REQ-007 sw_out  output  WIDTH  debounced, clk-synchronous switch levels; registered; feeds the seven-segment nibble decoders directly.
REQ-008 rise  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 0->1.
REQ-009 fall  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 1->0.
REQ-010 changed  output  1  one-cycle pulse when any sw_out bit changes; equals OR of rise and fall for that cycle.

Function
REQ-011 Each sw_in bit SHALL pass through a two-flop synchroniser (s1, s2) before any other logic; no other logic samples sw_in.
REQ-012 Each bit SHALL own a counter of width max(1, clog2(DEBOUNCE_CYCLES)) bits; bits are fully independent.
REQ-013 Per-bit states: STABLE (s2 equals sw_out, counter 0) and COUNTING (s2 differs from sw_out).
REQ-014 Per bit, each cycle: if s2 equals sw_out, counter SHALL clear to 0.
REQ-015 Else if counter equals DEBOUNCE_CYCLES-1, sw_out bit SHALL take s2 and counter SHALL clear to 0.
REQ-016 Else counter SHALL increment by 1; counter never wraps.
REQ-017 A glitch returning s2 to the sw_out level before acceptance SHALL discard the count; a later change restarts from 0.
REQ-018 Latency: a clean sw_in step SHALL appear on sw_out exactly 2 + DEBOUNCE_CYCLES rising edges after first sampled.
REQ-019 With DEBOUNCE_CYCLES = 1, a change SHALL be accepted on the first cycle s2 differs.
REQ-020 rise, fall, changed SHALL be registered and asserted in the same cycle sw_out takes its new value, for exactly one cycle.
REQ-021 Multiple bits accepted in the same cycle SHALL assert all their rise/fall bits together and a single changed pulse.
REQ-022 A pulse-width input shorter than DEBOUNCE_CYCLES cycles after synchronisation SHALL produce no output change and no pulses.

Reset
REQ-023 While rst_n is low: s1, s2 = RESET_VAL; sw_out = RESET_VAL; counters = 0; rise, fall, changed = 0.
REQ-024 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted on or after reset for that count.
REQ-025 If sw_in differs from RESET_VAL at reset release, the bit SHALL be accepted normally after 2 + DEBOUNCE_CYCLES cycles with its rise/fall and changed pulse.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VAL=0)
REQ-026 Reset, sw_in=0x00 held 20 cycles -> sw_out=0x00, rise/fall/changed never asserted.
REQ-027 sw_in 0x00->0x5A clean step -> sw_out=0x5A exactly 6 edges later; rise=0x5A and changed=1 for that one cycle; fall=0x00.
REQ-028 sw_in bit0 toggles every 2 cycles for 20 cycles, then holds 0 -> sw_out bit0 stays 0, no pulses.
REQ-029 sw_out=0x5A; sw_in->0x00 with bit1 bouncing 3 cycles first -> bits 3,4,6 fall after 6 edges; bit1 falls 3 cycles later; two separate changed pulses.
REQ-030 Reset asserted when bit7 counter=2 then released with sw_in=0x80 held -> no pulse in reset; sw_out=0x80, rise=0x80 6 edges after release.
REQ-031 Repeat REQ-027 with DEBOUNCE_CYCLES=1 -> sw_out=0x5A exactly 3 edges after step.

Source files
------------

// File: rtl/switch_debounce.sv
// Parallel switch debouncer: per-bit two-flop synchroniser plus a persistence counter.
// A new level is accepted after it holds for DEBOUNCE_CYCLES clocks. Rise, fall and
// changed pulses are registered and coincide with the sw_out update.
module switch_debounce #(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 120000,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]            s1_q, s1_d;
   logic [WIDTH-1:0]            s2_q, s2_d;
   logic [WIDTH-1:0]            sw_out_q, sw_out_d;
   logic [WIDTH-1:0]            rise_q, rise_d;
   logic [WIDTH-1:0]            fall_q, fall_d;
   logic                        changed_q, changed_d;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Synchroniser stages: the only logic that samples sw_in
   always_comb begin
      s1_d = sw_in;
      s2_d = s1_q;
   end

   // Per-bit accept logic; a bit is counting whenever s2 differs from the accepted level
   always_comb begin
      sw_out_d = sw_out_q;
      cnt_d    = cnt_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (s2_q[i] == sw_out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            sw_out_d[i] = s2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Edge pulses derived from the next accepted level so they land with sw_out
   always_comb begin
      rise_d    = sw_out_d & ~sw_out_q;
      fall_d    = ~sw_out_d & sw_out_q;
      changed_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= RESET_VAL;
         s2_q      <= RESET_VAL;
         sw_out_q  <= RESET_VAL;
         cnt_q     <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         sw_out_q  <= sw_out_d;
         cnt_q     <= cnt_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign sw_out  = sw_out_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign changed = changed_q;

endmodule
